// File: rtl/mem_stage_ctrl.sv
// MEM stage: lw/sw over a variable-latency req/ack data memory.
// Stalls the front of the pipe while waiting; registers MEM_WB.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              load_q, load_d;
  logic              m2r_q, m2r_d;
  logic              rw_q, rw_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic              mem_op;
  logic              misal;
  logic              load_i;
  logic              done;
  logic              fault;
  logic              c_rw;
  logic [REG_AW-1:0] c_rd;
  logic [DATA_W-1:0] c_alu;
  logic              c_load;
  logic              c_m2r;

  // Next-state, memory handshake, stall and MEM_WB update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    load_d       = load_q;
    m2r_d        = m2r_q;
    rw_d         = rw_q;
    rd_d         = rd_q;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    err_d        = err_q;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    stall_o      = 1'b0;
    done         = 1'b0;
    fault        = 1'b0;
    mem_op       = MemRead_i | MemWrite_i;
    misal        = |ALUResult_i[1:0];
    load_i       = MemRead_i & ~MemWrite_i;
    c_rw         = RegWrite_i;
    c_rd         = RDaddr_i;
    c_alu        = ALUResult_i;
    c_load       = load_i;
    c_m2r        = MemtoReg_i;
    case (state_q)
      S_IDLE: begin
        if (!mem_op) begin
          done = 1'b1;
        end else if (misal) begin
          done  = 1'b1;
          fault = 1'b1;
        end else begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = MemWrite_i;
          dmem_addr_o  = ALUResult_i;
          dmem_wdata_o = RTdata_i;
          if (dmem_ack_i) begin
            done = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = S_WAIT;
            cnt_d   = CW'(1);
            addr_d  = ALUResult_i;
            wdata_d = RTdata_i;
            we_d    = MemWrite_i;
            load_d  = load_i;
            m2r_d   = MemtoReg_i;
            rw_d    = RegWrite_i;
            rd_d    = RDaddr_i;
          end
        end
      end
      S_WAIT: begin
        c_rw         = rw_q;
        c_rd         = rd_q;
        c_alu        = addr_q;
        c_load       = load_q;
        c_m2r        = m2r_q;
        dmem_req_o   = 1'b1;
        dmem_we_o    = we_q;
        dmem_addr_o  = addr_q;
        dmem_wdata_o = wdata_q;
        if (dmem_ack_i) begin
          done    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO) begin
          done    = 1'b1;
          fault   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (done) begin
      wb_we_d   = c_rw & ~fault;
      wb_rd_d   = c_rd;
      wb_data_d = (c_m2r & c_load) ? dmem_rdata_i : c_alu;
      if (fault) begin
        err_d = 1'b1;
      end
    end
    if (!rst_i) begin
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_wdata_o = '0;
      stall_o      = 1'b0;
    end
  end

  // State, captured EX_MEM fields and MEM_WB registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      m2r_q     <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      load_q    <= load_d;
      m2r_q     <= m2r_d;
      rw_q      <= rw_d;
      rd_q      <= rd_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign RegWrite_o = wb_we_q;
  assign RDaddr_o   = wb_rd_q;
  assign WBdata_o   = wb_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl.
// Expected MEM_WB values are queued per cycle and popped after the edge.
module tb_mem_stage_ctrl;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] ALUResult_i;
  logic [31:0] RTdata_i;
  logic [4:0]  RDaddr_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] WBdata_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  mem_stage_ctrl #(
    .DATA_W (32),
    .REG_AW (5),
    .TIMEOUT(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ALUResult_i (ALUResult_i),
    .RTdata_i    (RTdata_i),
    .RDaddr_i    (RDaddr_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .RegWrite_i  (RegWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i  (dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i),
    .stall_o     (stall_o),
    .RegWrite_o  (RegWrite_o),
    .RDaddr_o    (RDaddr_o),
    .WBdata_o    (WBdata_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic setx(input logic rw, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] rt,
                      input logic mr, input logic mw,
                      input logic m2r);
    RegWrite_i  = rw;
    RDaddr_i    = rd;
    ALUResult_i = alu;
    RTdata_i    = rt;
    MemRead_i   = mr;
    MemWrite_i  = mw;
    MemtoReg_i  = m2r;
  endtask

  task automatic push(input logic rw, input logic [4:0] rd,
                      input logic [31:0] data, input logic err,
                      input bit cd);
    exp_t e;
    e.rw = rw;
    e.rd = rd;
    e.data = data;
    e.err = err;
    e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic ack,
                      input logic [31:0] rdata,
                      input logic e_req, input logic e_stall,
                      input logic e_we,
                      input logic [31:0] e_addr,
                      input logic [31:0] e_wdata);
    exp_t e;
    dmem_ack_i   = ack;
    dmem_rdata_i = rdata;
    #1;
    chk({tag, ".req"}, 32'(dmem_req_o), 32'(e_req));
    chk({tag, ".stall"}, 32'(stall_o), 32'(e_stall));
    chk({tag, ".we"}, 32'(dmem_we_o), 32'(e_we));
    chk({tag, ".addr"}, dmem_addr_o, e_addr);
    chk({tag, ".wdata"}, dmem_wdata_o, e_wdata);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb: observed empty queue expected entry",
             tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".rw"}, 32'(RegWrite_o), 32'(e.rw));
      chk({tag, ".rd"}, 32'(RDaddr_o), 32'(e.rd));
      if (e.chk_data) begin
        chk({tag, ".data"}, WBdata_o, e.data);
      end
      chk({tag, ".err"}, 32'(err_o), 32'(e.err));
    end
  endtask

  initial begin
    rst_i = 1'b0;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = '0;
    setx(0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    step("rst0", 0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    step("rst1", 1, 32'h1111, 0, 0, 0, 0, 0);
    rst_i = 1'b1;

    setx(1, 5, 32'h1234, 0, 0, 0, 0);
    push(1, 5, 32'h1234, 0, 1);
    step("alu", 0, 0, 0, 0, 0, 0, 0);

    setx(1, 8, 32'h10, 0, 1, 0, 1);
    push(1, 8, 32'hDEADBEEF, 0, 1);
    step("lw0", 1, 32'hDEADBEEF, 1, 0, 0, 32'h10, 0);

    setx(1, 9, 32'h10, 0, 1, 0, 1);
    push(0, 8, 32'hDEADBEEF, 0, 1);
    step("lw3a", 0, 0, 1, 1, 0, 32'h10, 0);
    setx(0, 31, 32'hFFF0, 32'h999, 0, 1, 0);
    push(0, 8, 32'hDEADBEEF, 0, 1);
    step("lw3b", 0, 0, 1, 1, 0, 32'h10, 0);
    push(0, 8, 32'hDEADBEEF, 0, 1);
    step("lw3c", 0, 0, 1, 1, 0, 32'h10, 0);
    push(1, 9, 32'hCAFEF00D, 0, 1);
    step("lw3d", 1, 32'hCAFEF00D, 1, 0, 0, 32'h10, 0);

    setx(0, 3, 32'h20, 32'hA5A5A5A5, 0, 1, 0);
    push(0, 9, 32'hCAFEF00D, 0, 1);
    step("swa", 0, 0, 1, 1, 1, 32'h20, 32'hA5A5A5A5);
    push(0, 3, 32'h20, 0, 1);
    step("swb", 1, 0, 1, 0, 1, 32'h20, 32'hA5A5A5A5);

    setx(1, 4, 32'h30, 32'h11, 1, 1, 1);
    push(1, 4, 32'h30, 0, 1);
    step("rdwr", 1, 32'hBAD0BAD0, 1, 0, 1, 32'h30, 32'h11);

    setx(1, 6, 32'h22, 0, 1, 0, 1);
    push(0, 6, 0, 1, 0);
    step("mis", 1, 32'h55, 0, 0, 0, 0, 0);
    setx(1, 7, 32'h77, 0, 0, 0, 0);
    push(1, 7, 32'h77, 1, 1);
    step("sticky", 1, 32'h66, 0, 0, 0, 0, 0);

    setx(1, 10, 32'h40, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      push(0, 7, 32'h77, 1, 1);
      step($sformatf("to%0d", i), 0, 0, 1, 1, 0, 32'h40, 0);
    end
    push(0, 10, 0, 1, 0);
    step("abort", 0, 0, 1, 0, 0, 32'h40, 0);
    setx(1, 11, 32'hAB, 0, 0, 0, 0);
    push(1, 11, 32'hAB, 1, 1);
    step("postab", 0, 0, 0, 0, 0, 0, 0);

    setx(1, 12, 32'h44, 0, 1, 0, 1);
    push(0, 11, 32'hAB, 1, 1);
    step("wait", 0, 0, 1, 1, 0, 32'h44, 0);
    rst_i = 1'b0;
    push(0, 0, 0, 0, 1);
    step("rstw", 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    setx(0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    step("idle", 1, 0, 0, 0, 0, 0, 0);
    setx(1, 13, 32'h48, 0, 1, 0, 1);
    push(1, 13, 32'h12345678, 0, 1);
    step("lwpr", 1, 32'h12345678, 1, 0, 0, 32'h48, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
